memory_bus_controller: RTL and testbench

//   Sits between the cpu memory port and the board: decodes every cpu access to block RAM or to

---
 rtl/memory_bus_controller.sv | 188 ++++++++++++++++++
 tb/tb_memory_bus_controller.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/memory_bus_controller.sv
// Purpose: decodes cpu word accesses into block RAM or memory-mapped I/O (switches, LEDs, timer, TX FIFO).
// Latency: cpu_read_data is valid one cycle after the address for both RAM and I/O; stores take effect on the next edge.
// Backpressure: the TX FIFO drains on tx_valid & tx_ready; pushes into a full FIFO are dropped and flagged as sticky overflow.
module memory_bus_controller #(
   parameter int          RAM_ADDRESS_WIDTH = 14,
   parameter logic [15:0] IO_BASE           = 16'hFF00,
   parameter int          FIFO_DEPTH        = 8
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         cpu_write_enable,
   input  logic [15:0]                  cpu_address,
   input  logic [15:0]                  cpu_write_data,
   output logic [15:0]                  cpu_read_data,
   output logic                         ram_write_enable,
   output logic [RAM_ADDRESS_WIDTH-1:0] ram_address,
   output logic [15:0]                  ram_write_data,
   input  logic [15:0]                  ram_read_data,
   input  logic [15:0]                  switches,
   output logic [15:0]                  leds,
   output logic [7:0]                   tx_data,
   output logic                         tx_valid,
   input  logic                         tx_ready
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;

   localparam logic [7:0] OFS_SWITCH    = 8'h00;
   localparam logic [7:0] OFS_LED       = 8'h01;
   localparam logic [7:0] OFS_TIMER     = 8'h02;
   localparam logic [7:0] OFS_TX_DATA   = 8'h03;
   localparam logic [7:0] OFS_TX_STATUS = 8'h04;

   // address decode
   logic       is_io;
   logic [7:0] io_offset;
   logic       io_write;
   logic       led_write;
   logic       timer_write;
   logic       fifo_push;
   logic       status_write;

   // switch synchroniser
   logic [15:0] switch_meta;
   logic [15:0] switch_sync;

   // timer
   logic [15:0] timer;

   // TX FIFO
   logic [7:0]       fifo_mem [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic [CNT_W-1:0] fifo_count;
   logic             fifo_full;
   logic             fifo_empty;
   logic             fifo_pop;
   logic             push_accept;
   logic             overflow;
   logic [4:0]       count_ext;
   logic [2:0]       status_count;

   // read path
   logic [15:0] io_read_value;
   logic [15:0] io_read_q;
   logic        read_is_io;
   logic        read_blank;

   // Region decode; the offset only needs the low byte since the I/O window is 256 words.
   assign is_io        = (cpu_address >= IO_BASE);
   assign io_offset    = cpu_address[7:0] - IO_BASE[7:0];
   assign io_write     = cpu_write_enable & is_io;
   assign led_write    = io_write & (io_offset == OFS_LED);
   assign timer_write  = io_write & (io_offset == OFS_TIMER);
   assign fifo_push    = io_write & (io_offset == OFS_TX_DATA);
   assign status_write = io_write & (io_offset == OFS_TX_STATUS);

   assign ram_write_enable = cpu_write_enable & ~is_io;
   assign ram_address      = cpu_address[RAM_ADDRESS_WIDTH-1:0];
   assign ram_write_data   = cpu_write_data;

   // Two-flop synchroniser for the asynchronous board switches.
   always_ff @(posedge clock) begin
      if (reset) begin
         switch_meta <= '0;
         switch_sync <= '0;
      end else begin
         switch_meta <= switches;
         switch_sync <= switch_meta;
      end
   end

   // LED register, written only through its I/O offset.
   always_ff @(posedge clock) begin
      if (reset) begin
         leds <= '0;
      end else if (led_write) begin
         leds <= cpu_write_data;
      end
   end

   // Free-running timer; a store loads it and counting resumes from the loaded value.
   always_ff @(posedge clock) begin
      if (reset) begin
         timer <= '0;
      end else if (timer_write) begin
         timer <= cpu_write_data;
      end else begin
         timer <= timer + 16'd1;
      end
   end

   // A push into a full FIFO is still accepted when a pop frees a slot in the same cycle.
   assign fifo_full   = (fifo_count == CNT_W'(FIFO_DEPTH));
   assign fifo_empty  = (fifo_count == '0);
   assign fifo_pop    = tx_valid & tx_ready;
   assign push_accept = fifo_push & (~fifo_full | fifo_pop);
   assign tx_valid    = ~fifo_empty;
   assign tx_data     = fifo_mem[rd_ptr];

   // FIFO storage; contents need no reset because the pointers define validity.
   always_ff @(posedge clock) begin
      if (push_accept) begin
         fifo_mem[wr_ptr] <= cpu_write_data[7:0];
      end
   end

   // FIFO pointers, occupancy and sticky overflow flag.
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         fifo_count <= '0;
         overflow   <= 1'b0;
      end else begin
         if (push_accept) begin
            wr_ptr <= wr_ptr + PTR_W'(1);
         end
         if (fifo_pop) begin
            rd_ptr <= rd_ptr + PTR_W'(1);
         end
         case ({push_accept, fifo_pop})
            2'b10:   fifo_count <= fifo_count + CNT_W'(1);
            2'b01:   fifo_count <= fifo_count - CNT_W'(1);
            default: fifo_count <= fifo_count;
         endcase
         if (fifo_push & fifo_full & ~fifo_pop) begin
            overflow <= 1'b1;
         end else if (status_write) begin
            overflow <= 1'b0;
         end
      end
   end

   // Status count field is only three bits wide, so it saturates at 7.
   assign count_ext    = 5'(fifo_count);
   assign status_count = (count_ext > 5'd7) ? 3'd7 : count_ext[2:0];

   // I/O read mux, evaluated in the address cycle.
   always_comb begin
      io_read_value = '0;
      case (io_offset)
         OFS_SWITCH:    io_read_value = switch_sync;
         OFS_LED:       io_read_value = leds;
         OFS_TIMER:     io_read_value = timer;
         OFS_TX_STATUS: io_read_value = {overflow, 10'b0, fifo_full, fifo_empty, status_count};
         default:       io_read_value = '0;
      endcase
   end

   // Register the region select and I/O value so both paths present data one cycle later.
   always_ff @(posedge clock) begin
      if (reset) begin
         read_is_io <= 1'b0;
         io_read_q  <= '0;
         read_blank <= 1'b1;
      end else begin
         read_is_io <= is_io;
         io_read_q  <= io_read_value;
         read_blank <= 1'b0;
      end
   end

   // Read data is forced to zero for the cycle following reset.
   assign cpu_read_data = read_blank ? 16'h0000 : (read_is_io ? io_read_q : ram_read_data);

endmodule

// File: tb/tb_memory_bus_controller.sv
// Scoreboard bench for memory_bus_controller: stimulus pushes expectations, a negedge monitor checks them.
module tb_memory_bus_controller;

   logic        clock = 1'b0;
   logic        reset;
   logic        cpu_write_enable;
   logic [15:0] cpu_address;
   logic [15:0] cpu_write_data;
   logic [15:0] cpu_read_data;
   logic        ram_write_enable;
   logic [13:0] ram_address;
   logic [15:0] ram_write_data;
   logic [15:0] ram_read_data;
   logic [15:0] switches;
   logic [15:0] leds;
   logic [7:0]  tx_data;
   logic        tx_valid;
   logic        tx_ready;

   always #5 clock = ~clock;

   memory_bus_controller dut (
      .clock            (clock),
      .reset            (reset),
      .cpu_write_enable (cpu_write_enable),
      .cpu_address      (cpu_address),
      .cpu_write_data   (cpu_write_data),
      .cpu_read_data    (cpu_read_data),
      .ram_write_enable (ram_write_enable),
      .ram_address      (ram_address),
      .ram_write_data   (ram_write_data),
      .ram_read_data    (ram_read_data),
      .switches         (switches),
      .leds             (leds),
      .tx_data          (tx_data),
      .tx_valid         (tx_valid),
      .tx_ready         (tx_ready)
   );

   // Board block RAM with synchronous read.
   logic [15:0] bram [0:16383];
   always @(posedge clock) begin
      if (ram_write_enable) bram[ram_address] <= ram_write_data;
      ram_read_data <= bram[ram_address];
   end

   typedef struct {
      int          cyc;
      logic        wren;
      logic [13:0] addr;
      logic [15:0] wdat;
      logic [15:0] leds;
      logic        txv;
   } cyc_exp_t;

   typedef struct {
      int          cyc;
      logic [15:0] data;
   } rd_exp_t;

   cyc_exp_t    cyc_q[$];
   rd_exp_t     rd_q[$];
   logic [7:0]  tx_q[$];

   // Reference model state
   logic [15:0] ref_mem [int];
   logic [15:0] m_leds;
   logic [15:0] m_timer;
   logic [7:0]  m_fifo[$];
   logic        m_ovf;
   logic [15:0] m_s1;
   logic [15:0] m_s2;
   bit          m_valid = 1'b0;

   bit          rdy;
   logic [15:0] sw_val;
   int          cyc = 0;
   int          errors = 0;
   int          checks = 0;
   bit          done = 1'b0;
   bit          final_done = 1'b0;

   function automatic logic [15:0] ram_ref(input logic [13:0] a);
      int k;
      k = int'(a);
      return ref_mem.exists(k) ? ref_mem[k] : 16'h0000;
   endfunction

   function automatic logic [15:0] status_ref();
      logic [2:0] sat;
      int n;
      n = m_fifo.size();
      sat = (n > 7) ? 3'd7 : 3'(n);
      return {m_ovf, 10'b0, (n == 8) ? 1'b1 : 1'b0, (n == 0) ? 1'b1 : 1'b0, sat};
   endfunction

   function automatic logic [15:0] io_ref(input logic [7:0] ofs);
      case (ofs)
         8'h00:   return m_s2;
         8'h01:   return m_leds;
         8'h02:   return m_timer;
         8'h04:   return status_ref();
         default: return 16'h0000;
      endcase
   endfunction

   task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cyc=%0d got=%h want=%h", name, cyc, act, exp);
      end
   endtask

   // One bus cycle: drive inputs, record expectations, advance the model, wait for the edge.
   task automatic step(input bit rst, input bit we, input logic [15:0] addr,
                       input logic [15:0] data, input bit load);
      bit         io;
      logic [7:0] ofs;
      bit         pop;
      bit         push;
      bit         full;
      cyc_exp_t   ce;
      rd_exp_t    re;
      reset            = rst;
      cpu_write_enable = we;
      cpu_address      = addr;
      cpu_write_data   = data;
      switches         = sw_val;
      tx_ready         = rdy;
      io  = (addr >= 16'hFF00);
      ofs = addr[7:0];
      if (m_valid) begin
         ce.cyc  = cyc;
         ce.wren = we && !io;
         ce.addr = addr[13:0];
         ce.wdat = data;
         ce.leds = m_leds;
         ce.txv  = (m_fifo.size() != 0);
         cyc_q.push_back(ce);
      end
      if (rst) begin
         re.cyc = cyc + 1; re.data = 16'h0000; rd_q.push_back(re);
      end else if (load && !we) begin
         re.cyc = cyc + 1; re.data = io ? io_ref(ofs) : ram_ref(addr[13:0]); rd_q.push_back(re);
      end
      pop = m_valid && (m_fifo.size() != 0) && rdy;
      if (pop) tx_q.push_back(m_fifo[0]);
      if (rst) begin
         m_leds = '0; m_timer = '0; m_fifo.delete(); m_ovf = 1'b0;
         m_s1 = '0; m_s2 = '0; m_valid = 1'b1;
      end else begin
         full = (m_fifo.size() == 8);
         push = we && io && (ofs == 8'h03);
         m_s2 = m_s1;
         m_s1 = sw_val;
         if (we && !io) ref_mem[int'(addr[13:0])] = data;
         if (we && io && ofs == 8'h02) m_timer = data;
         else m_timer = m_timer + 16'd1;
         if (we && io && ofs == 8'h01) m_leds = data;
         if (we && io && ofs == 8'h04) m_ovf = 1'b0;
         if (pop) void'(m_fifo.pop_front());
         if (push) begin
            if (full && !pop) m_ovf = 1'b1;
            else m_fifo.push_back(data[7:0]);
         end
      end
      @(posedge clock);
      #1;
      cyc++;
   endtask

   task automatic idle(input int n);
      for (int k = 0; k < n; k++) step(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0);
   endtask

   // Monitor: compare whatever the DUT presents against the queued expectations.
   always @(negedge clock) begin
      cyc_exp_t e;
      rd_exp_t  r;
      logic [7:0] t;
      if (cyc_q.size() > 0 && cyc_q[0].cyc == cyc) begin
         e = cyc_q.pop_front();
         chk("ram_write_enable", {15'b0, ram_write_enable}, {15'b0, e.wren});
         chk("ram_address", {2'b0, ram_address}, {2'b0, e.addr});
         chk("ram_write_data", ram_write_data, e.wdat);
         chk("leds", leds, e.leds);
         chk("tx_valid", {15'b0, tx_valid}, {15'b0, e.txv});
      end
      if (rd_q.size() > 0 && rd_q[0].cyc == cyc) begin
         r = rd_q.pop_front();
         chk("cpu_read_data", cpu_read_data, r.data);
      end
      if (tx_valid === 1'b1 && tx_ready === 1'b1) begin
         if (tx_q.size() == 0) begin
            chk("tx_unexpected_pop", {8'h00, tx_data}, 16'hFFFF);
         end else begin
            t = tx_q.pop_front();
            chk("tx_data", {8'h00, tx_data}, {8'h00, t});
         end
      end
      if (done && !final_done) begin
         chk("leftover_reads", 16'(rd_q.size()), 16'd0);
         chk("leftover_tx", 16'(tx_q.size()), 16'd0);
         final_done = 1'b1;
      end
   end

   initial begin
      for (int i = 0; i < 16384; i++) bram[i] = 16'h0000;
      rdy = 1'b0;
      sw_val = 16'h5A3C;
      reset = 1'b1; cpu_write_enable = 1'b0; cpu_address = '0; cpu_write_data = '0;
      switches = sw_val; tx_ready = 1'b0;
      @(posedge clock);
      #1;
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);
      step(1'b1, 1'b0, 16'h0000, 16'h0000, 1'b0);

      // RAM store then load
      step(1'b0, 1'b1, 16'h0010, 16'h1234, 1'b0);
      step(1'b0, 1'b0, 16'h0010, 16'h0000, 1'b1);
      // LED store and readback, switch readback
      step(1'b0, 1'b1, 16'hFF01, 16'h00A5, 1'b0);
      step(1'b0, 1'b0, 16'hFF01, 16'h0000, 1'b1);
      step(1'b0, 1'b0, 16'hFF00, 16'h0000, 1'b1);
      // Timer load and wrap
      step(1'b0, 1'b1, 16'hFF02, 16'hFFFE, 1'b0);
      idle(2);
      step(1'b0, 1'b0, 16'hFF02, 16'h0000, 1'b1);
      // Overflow: nine pushes with the transmitter stalled
      for (int i = 1; i <= 9; i++) step(1'b0, 1'b1, 16'hFF03, 16'(i), 1'b0);
      step(1'b0, 1'b0, 16'hFF04, 16'h0000, 1'b1);
      rdy = 1'b1;
      idle(9);
      step(1'b0, 1'b1, 16'hFF04, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'hFF04, 16'h0000, 1'b1);
      // Push and pop together while full
      rdy = 1'b0;
      for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 16'hFF03, 16'h0011 + 16'(i), 1'b0);
      step(1'b0, 1'b0, 16'hFF04, 16'h0000, 1'b1);
      rdy = 1'b1;
      step(1'b0, 1'b1, 16'hFF03, 16'h005A, 1'b0);
      rdy = 1'b0;
      step(1'b0, 1'b0, 16'hFF04, 16'h0000, 1'b1);
      rdy = 1'b1;
      idle(9);
      // Reset with LEDs lit and bytes queued
      rdy = 1'b0;
      step(1'b0, 1'b1, 16'hFF01, 16'hFFFF, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b0, 1'b1, 16'hFF03, 16'h00C0 + 16'(i), 1'b0);
      step(1'b1, 1'b0, 16'hFF04, 16'h0000, 1'b0);
      step(1'b0, 1'b0, 16'hFF04, 16'h0000, 1'b1);

      // Randomised traffic
      for (int i = 0; i < 4000; i++) begin
         bit          r_rst;
         bit          r_we;
         logic [15:0] r_addr;
         logic [7:0]  r_ofs;
         rdy = ($urandom_range(0, 99) < ((i % 1000) < 500 ? 15 : 75));
         if ($urandom_range(0, 49) == 0) sw_val = 16'($urandom);
         r_rst = ($urandom_range(0, 299) == 0);
         r_we  = !r_rst && ($urandom_range(0, 99) < 40);
         if ($urandom_range(0, 1) == 0) begin
            r_addr = 16'($urandom_range(0, 31)) | (16'($urandom_range(0, 3)) << 14);
         end else begin
            r_ofs = 8'($urandom_range(0, 6));
            if ($urandom_range(0, 2) == 0) r_ofs = 8'h03;
            if ($urandom_range(0, 19) == 0) r_ofs = 8'($urandom_range(0, 255));
            r_addr = {8'hFF, r_ofs};
         end
         step(r_rst, r_we, r_addr, 16'($urandom), !r_we);
      end

      rdy = 1'b1;
      idle(12);
      done = 1'b1;
      @(negedge clock);
      @(negedge clock);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
